// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared types for the HI/LO multiply/divide scheduler.
// Rev    : 1.0
// ============================================================================
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_DRAIN    = 2'd3
    } mdu_state_t;

    localparam logic [1:0] UNIT_OP_SIGNED   = 2'b10;
    localparam logic [1:0] UNIT_OP_UNSIGNED = 2'b01;
    localparam logic [1:0] UNIT_OP_NONE     = 2'b00;

endpackage
`default_nettype wire

// File: rtl/mdu_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : mdu_scheduler_if
// Brief  : Slot, pipeline-control and multiplier/divider signals of the scheduler.
// Rev    : 1.0
// ============================================================================
interface mdu_scheduler_if;
    import mdu_pkg::*;

    logic          stall_i;
    logic          flush_i;
    mdu_op_t       s0_op_i;
    mdu_op_t       s1_op_i;
    logic [31:0]   s0_a_i;
    logic [31:0]   s0_b_i;
    logic [31:0]   s1_a_i;
    logic [31:0]   s1_b_i;
    logic [31:0]   s0_rdata_o;
    logic [31:0]   s1_rdata_o;
    logic          stall_o;
    logic          busy_o;
    logic [1:0]    mul_op_o;
    logic [1:0]    div_op_o;
    logic [31:0]   mul_a_o;
    logic [31:0]   mul_b_o;
    logic [31:0]   div_a_o;
    logic [31:0]   div_b_o;
    logic          mul_done_i;
    logic          div_done_i;
    logic [63:0]   mul_result_i;
    logic [63:0]   div_result_i;

    modport slave (
        input  stall_i, flush_i, s0_op_i, s1_op_i, s0_a_i, s0_b_i, s1_a_i, s1_b_i,
        input  mul_done_i, div_done_i, mul_result_i, div_result_i,
        output s0_rdata_o, s1_rdata_o, stall_o, busy_o,
        output mul_op_o, div_op_o, mul_a_o, mul_b_o, div_a_o, div_b_o
    );

    modport master (
        output stall_i, flush_i, s0_op_i, s1_op_i, s0_a_i, s0_b_i, s1_a_i, s1_b_i,
        output mul_done_i, div_done_i, mul_result_i, div_result_i,
        input  s0_rdata_o, s1_rdata_o, stall_o, busy_o,
        input  mul_op_o, div_op_o, mul_a_o, mul_b_o, div_a_o, div_b_o
    );

endinterface
`default_nettype wire

// File: rtl/mdu_op_decode.sv
`default_nettype none
// ============================================================================
// Module : mdu_op_decode
// Brief  : Classifies one slot's HI/LO op into start / write / read classes.
// Rev    : 1.0
// ============================================================================
module mdu_op_decode
    import mdu_pkg::*;
(
    input  var mdu_op_t op,
    output logic        is_start,
    output logic        is_write,
    output logic        is_read,
    output logic        is_signed,
    output logic        is_mul
);

    always_comb begin
        is_start  = 1'b0;
        is_write  = 1'b0;
        is_read   = 1'b0;
        is_signed = 1'b0;
        is_mul    = 1'b0;
        case (op)
            OP_MULT:  begin is_start = 1'b1; is_signed = 1'b1; is_mul = 1'b1; end
            OP_MULTU: begin is_start = 1'b1; is_mul = 1'b1; end
            OP_DIV:   begin is_start = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_start = 1'b1;
            OP_MTHI, OP_MTLO: is_write = 1'b1;
            OP_MFHI, OP_MFLO: is_read  = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module : mdu_scheduler
// Brief  : Owns HI/LO, shares one multiplier and one divider between two slots.
//          Slot 1 and the bundle split exist only with MDU_DUAL_ISSUE_EN defined.
// Rev    : 1.0
// ============================================================================
module mdu_scheduler
    import mdu_pkg::*;
#(
    parameter logic [63:0] RST_HILO = 64'h0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mdu_scheduler_if.slave bus
);

    mdu_state_t  state;
    logic [63:0] hilo;
    logic        mul_done_prev;
    logic        div_done_prev;

    mdu_op_t     s0_op;
    logic        s0_start, s0_write, s0_read, s0_signed, s0_mul;
    logic        en, busy, s0_valid, s0_acc;
    logic        mul_rise, div_rise;
    logic        st_fire, st_signed, st_mul;
    logic [31:0] st_a, st_b;
    logic        wr_fire;
    logic [63:0] wr_hilo;

    assign en       = ~bus.stall_i & ~bus.flush_i;
    assign busy     = (state != ST_IDLE);
    assign mul_rise = bus.mul_done_i & ~mul_done_prev;
    assign div_rise = bus.div_done_i & ~div_done_prev;

    mdu_op_decode u_dec0 (
        .op(s0_op), .is_start(s0_start), .is_write(s0_write),
        .is_read(s0_read), .is_signed(s0_signed), .is_mul(s0_mul)
    );

    assign s0_valid = (s0_op != OP_NONE);
    assign s0_acc   = en & s0_valid & ~busy;
    assign bus.s0_rdata_o = !s0_read ? 32'h0 :
                            (s0_op == OP_MFHI) ? hilo[63:32] : hilo[31:0];

`ifdef MDU_DUAL_ISSUE_EN
    logic    s0_done;
    mdu_op_t s1_op;
    logic    s1_start, s1_write, s1_read, s1_signed, s1_mul;
    logic    s1_valid, s1_acc, split;

    assign s1_op = bus.s1_op_i;
    mdu_op_decode u_dec1 (
        .op(s1_op), .is_start(s1_start), .is_write(s1_write),
        .is_read(s1_read), .is_signed(s1_signed), .is_mul(s1_mul)
    );

    // Once slot 0 of a split bundle has gone, it is masked until slot 1 leaves.
    assign s0_op    = s0_done ? OP_NONE : bus.s0_op_i;
    assign s1_valid = (s1_op != OP_NONE);
    assign split    = (s0_start | s0_write) & s1_valid;
    assign s1_acc   = en & s1_valid & ~busy & ~split;
    assign bus.stall_o = en & ((busy & (s0_valid | s1_valid)) | split);
    assign bus.s1_rdata_o = !s1_read ? 32'h0 :
                            (s1_op == OP_MFHI) ? hilo[63:32] : hilo[31:0];
`else
    logic unused_s1;
    assign unused_s1   = ^{bus.s1_op_i, bus.s1_a_i, bus.s1_b_i};
    assign s0_op       = bus.s0_op_i;
    assign bus.stall_o = en & busy & s0_valid;
    assign bus.s1_rdata_o = 32'h0;
`endif

    // At most one start and one write can fire per cycle; slot 0 is older.
    always_comb begin
        st_fire   = 1'b0;
        st_signed = 1'b0;
        st_mul    = 1'b0;
        st_a      = 32'h0;
        st_b      = 32'h0;
        wr_fire   = 1'b0;
        wr_hilo   = hilo;
        if (s0_acc && s0_start) begin
            st_fire = 1'b1; st_signed = s0_signed; st_mul = s0_mul;
            st_a = bus.s0_a_i; st_b = bus.s0_b_i;
        end
`ifdef MDU_DUAL_ISSUE_EN
        else if (s1_acc && s1_start) begin
            st_fire = 1'b1; st_signed = s1_signed; st_mul = s1_mul;
            st_a = bus.s1_a_i; st_b = bus.s1_b_i;
        end
`endif
        if (s0_acc && s0_write) begin
            wr_fire = 1'b1;
            wr_hilo = (s0_op == OP_MTHI) ? {bus.s0_a_i, hilo[31:0]} : {hilo[63:32], bus.s0_a_i};
        end
`ifdef MDU_DUAL_ISSUE_EN
        else if (s1_acc && s1_write) begin
            wr_fire = 1'b1;
            wr_hilo = (s1_op == OP_MTHI) ? {bus.s1_a_i, hilo[31:0]} : {hilo[63:32], bus.s1_a_i};
        end
`endif
    end

    assign bus.mul_op_o = (st_fire &  st_mul) ? (st_signed ? UNIT_OP_SIGNED : UNIT_OP_UNSIGNED) : UNIT_OP_NONE;
    assign bus.div_op_o = (st_fire & ~st_mul) ? (st_signed ? UNIT_OP_SIGNED : UNIT_OP_UNSIGNED) : UNIT_OP_NONE;
    assign bus.mul_a_o  = (st_fire &  st_mul) ? st_a : 32'h0;
    assign bus.mul_b_o  = (st_fire &  st_mul) ? st_b : 32'h0;
    assign bus.div_a_o  = (st_fire & ~st_mul) ? st_a : 32'h0;
    assign bus.div_b_o  = (st_fire & ~st_mul) ? st_b : 32'h0;
    assign bus.busy_o   = busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            hilo          <= RST_HILO;
            mul_done_prev <= 1'b1;
            div_done_prev <= 1'b1;
`ifdef MDU_DUAL_ISSUE_EN
            s0_done       <= 1'b0;
`endif
        end else begin
            mul_done_prev <= bus.mul_done_i;
            div_done_prev <= bus.div_done_i;
            case (state)
                ST_IDLE: begin
                    if (wr_fire) hilo  <= wr_hilo;
                    if (st_fire) state <= st_mul ? ST_MUL_WAIT : ST_DIV_WAIT;
                end
                // Commit takes priority over a same-cycle flush.
                ST_MUL_WAIT: begin
                    if (mul_rise) begin
                        hilo  <= bus.mul_result_i;
                        state <= ST_IDLE;
                    end else if (bus.flush_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_rise) begin
                        hilo  <= bus.div_result_i;
                        state <= ST_IDLE;
                    end else if (bus.flush_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (mul_rise || div_rise) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
`ifdef MDU_DUAL_ISSUE_EN
            if (bus.flush_i || s1_acc) s0_done <= 1'b0;
            else if (s0_acc && split)  s0_done <= 1'b1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_mdu_scheduler
// Brief  : Self-checking bench with multiplier/divider models and a read scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_mdu_scheduler;
    import mdu_pkg::*;

    localparam logic [63:0] C_RST_HILO = 64'hDEAD_BEEF_0BAD_F00D;
    localparam int          C_LAT      = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [31:0] exp_q[$];

    mdu_scheduler_if bus_if ();

    mdu_scheduler #(.RST_HILO(C_RST_HILO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mdl_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = (op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 2'b10) ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    function automatic logic [63:0] mdl_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (op == 2'b10) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Multi-cycle unit models: done low from the cycle after start, high again C_LAT cycles later.
    int mul_cnt, div_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_if.mul_done_i   <= 1'b1;
            bus_if.mul_result_i <= 64'h0;
            mul_cnt             <= 0;
        end else if (bus_if.mul_op_o != 2'b00) begin
            bus_if.mul_done_i   <= 1'b0;
            bus_if.mul_result_i <= mdl_mul(bus_if.mul_op_o, bus_if.mul_a_o, bus_if.mul_b_o);
            mul_cnt             <= C_LAT;
        end else if (!bus_if.mul_done_i) begin
            if (mul_cnt == 1) bus_if.mul_done_i <= 1'b1;
            mul_cnt <= mul_cnt - 1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_if.div_done_i   <= 1'b1;
            bus_if.div_result_i <= 64'h0;
            div_cnt             <= 0;
        end else if (bus_if.div_op_o != 2'b00) begin
            bus_if.div_done_i   <= 1'b0;
            bus_if.div_result_i <= mdl_div(bus_if.div_op_o, bus_if.div_a_o, bus_if.div_b_o);
            div_cnt             <= C_LAT;
        end else if (!bus_if.div_done_i) begin
            if (div_cnt == 1) bus_if.div_done_i <= 1'b1;
            div_cnt <= div_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input mdu_op_t op0, input logic [31:0] a0, input logic [31:0] b0,
                         input mdu_op_t op1, input logic [31:0] a1, input logic [31:0] b1);
        bus_if.s0_op_i = op0; bus_if.s0_a_i = a0; bus_if.s0_b_i = b0;
        bus_if.s1_op_i = op1; bus_if.s1_a_i = a1; bus_if.s1_b_i = b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        drive(OP_NONE, 0, 0, OP_NONE, 0, 0);
    endtask

    // Issue a slot-0 read; its expected value waits in the scoreboard until the op is accepted.
    task automatic read_chk(input string tag, input mdu_op_t op, input logic [31:0] exp, input int exp_stalls);
        int waited;
        logic [31:0] want;
        exp_q.push_back(exp);
        drive(op, 0, 0, OP_NONE, 0, 0);
        waited = 0;
        @(negedge clk);
        while (bus_if.stall_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_stall_timeout"}, bus_if.stall_o, 1'b0);
        if (exp_stalls >= 0) check({tag, "_stall_cycles"}, waited, exp_stalls);
        want = exp_q.pop_front();
        check(tag, bus_if.s0_rdata_o, want);
        next_cycle();
    endtask

    task automatic start_chk(input string tag, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] exp_mul, input logic [1:0] exp_div);
        drive(op, a, b, OP_NONE, 0, 0);
        @(negedge clk);
        check({tag, "_mul_op"}, bus_if.mul_op_o, exp_mul);
        check({tag, "_div_op"}, bus_if.div_op_o, exp_div);
        if (exp_mul != 2'b00) begin
            check({tag, "_mul_a"}, bus_if.mul_a_o, a);
            check({tag, "_mul_b"}, bus_if.mul_b_o, b);
        end else begin
            check({tag, "_div_a"}, bus_if.div_a_o, a);
            check({tag, "_div_b"}, bus_if.div_b_o, b);
        end
        check({tag, "_stall"}, bus_if.stall_o, 1'b0);
        next_cycle();
    endtask

    task automatic write_op(input mdu_op_t op, input logic [31:0] a);
        drive(op, a, 0, OP_NONE, 0, 0);
        @(negedge clk);
        check("write_stall", bus_if.stall_o, 1'b0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus_if.stall_i = 1'b0;
        bus_if.flush_i = 1'b0;
        drive(OP_NONE, 0, 0, OP_NONE, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", bus_if.stall_o, 1'b0);
        check("rst_busy", bus_if.busy_o, 1'b0);
        check("rst_mul_op", bus_if.mul_op_o, 2'b00);
        check("rst_div_op", bus_if.div_op_o, 2'b00);
        check("rst_mul_a", bus_if.mul_a_o, 32'h0);
        rst = 1'b1;
        next_cycle();

        read_chk("rst_hi", OP_MFHI, C_RST_HILO[63:32], 0);
        read_chk("rst_lo", OP_MFLO, C_RST_HILO[31:0], 0);

        // Signed multiply; the dependent read stalls across the whole unit latency.
        start_chk("mult", OP_MULT, 32'hFFFF_FFFF, 32'd2, 2'b10, 2'b00);
        read_chk("mult_lo", OP_MFLO, 32'hFFFF_FFFE, C_LAT + 1);
        read_chk("mult_hi", OP_MFHI, 32'hFFFF_FFFF, 0);

        start_chk("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 2'b01, 2'b00);
        read_chk("multu_hi", OP_MFHI, 32'h0000_0001, C_LAT + 1);
        read_chk("multu_lo", OP_MFLO, 32'hFFFF_FFFE, 0);

        start_chk("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b10);
        read_chk("div_lo", OP_MFLO, 32'hFFFF_FFFD, C_LAT + 1);
        read_chk("div_hi", OP_MFHI, 32'hFFFF_FFFF, 0);

        write_op(OP_MTHI, 32'h0000_1234);
        read_chk("mthi", OP_MFHI, 32'h0000_1234, 0);
        write_op(OP_MTLO, 32'h0000_0005);
        read_chk("mtlo", OP_MFLO, 32'h0000_0005, 0);
        read_chk("mtlo_hi_kept", OP_MFHI, 32'h0000_1234, 0);

        // A write presented under a downstream stall must not land.
        bus_if.stall_i = 1'b1;
        drive(OP_MTLO, 32'h9, 0, OP_NONE, 0, 0);
        @(negedge clk);
        check("stall_in_stall_o", bus_if.stall_o, 1'b0);
        next_cycle();
        bus_if.stall_i = 1'b0;
        read_chk("stall_in_lo", OP_MFLO, 32'h0000_0005, 0);

`ifndef MDU_DUAL_ISSUE_EN
        drive(OP_NONE, 0, 0, OP_MTLO, 32'h77, 0);
        @(negedge clk);
        check("s1_ign_stall", bus_if.stall_o, 1'b0);
        next_cycle();
        drive(OP_NONE, 0, 0, OP_MFHI, 0, 0);
        @(negedge clk);
        check("s1_ign_rdata", bus_if.s1_rdata_o, 32'h0);
        next_cycle();
        read_chk("s1_ign_lo", OP_MFLO, 32'h0000_0005, 0);
`endif

        // Flushed divide drains without touching HI/LO.
        start_chk("flush_div", OP_DIVU, 32'd100, 32'd7, 2'b00, 2'b01);
        bus_if.flush_i = 1'b1;
        @(negedge clk);
        check("flush_stall", bus_if.stall_o, 1'b0);
        check("flush_busy", bus_if.busy_o, 1'b1);
        next_cycle();
        bus_if.flush_i = 1'b0;
        w = 0;
        @(negedge clk);
        while (!bus_if.div_done_i && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("drain_done_timeout", bus_if.div_done_i, 1'b1);
        check("drain_busy_at_edge", bus_if.busy_o, 1'b1);
        @(negedge clk);
        check("drain_busy_after", bus_if.busy_o, 1'b0);
        next_cycle();
        read_chk("drain_hi", OP_MFHI, 32'h0000_1234, 0);
        read_chk("drain_lo", OP_MFLO, 32'h0000_0005, 0);

`ifdef MDU_DUAL_ISSUE_EN
        // Write then dependent read in one bundle: one split cycle.
        drive(OP_MTHI, 32'h0000_ABCD, 0, OP_MFHI, 0, 0);
        @(negedge clk);
        check("split_stall", bus_if.stall_o, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("split_release", bus_if.stall_o, 1'b0);
        check("split_s1_rdata", bus_if.s1_rdata_o, 32'h0000_ABCD);
        next_cycle();
        read_chk("split_s0_done_clear", OP_MFHI, 32'h0000_ABCD, 0);

        // Read in slot 0 with divide in slot 1 issues together.
        drive(OP_MFLO, 0, 0, OP_DIVU, 32'd7, 32'd2);
        @(negedge clk);
        check("pair_stall", bus_if.stall_o, 1'b0);
        check("pair_s0_rdata", bus_if.s0_rdata_o, 32'h0000_0005);
        check("pair_div_op", bus_if.div_op_o, 2'b01);
        check("pair_div_a", bus_if.div_a_o, 32'd7);
        check("pair_div_b", bus_if.div_b_o, 32'd2);
        next_cycle();
        read_chk("pair_hi", OP_MFHI, 32'h0000_0001, C_LAT + 1);
        read_chk("pair_lo", OP_MFLO, 32'h0000_0003, 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_scheduler.md
# mdu_scheduler

Controller that owns the HI/LO register pair and shares one multiplier and one divider between the two execute slots (slot 0 older, slot 1 younger in program order). It issues start commands to the multi-cycle units, captures their results on completion, orders HI/LO reads, writes and starts within and across bundles, and raises a pipeline stall while any ordering hazard is open. It sits in EX beside both ALUs; the ALUs no longer hold HI/LO themselves.

## Interface
- RST_HILO, 64'h0, HI/LO reset value; HI is bits [63:32].
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall_i  in  1  downstream pipeline stall; no op is accepted.
- flush_i  in  1  kill EX contents; no op is accepted.
- s0_op_i, s1_op_i  in  4  slot op, mdu_op_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- s0_a_i, s0_b_i, s1_a_i, s1_b_i  in  32  slot operands. MTHI/MTLO use a.
- s0_rdata_o, s1_rdata_o  out  32  HI for MFHI, LO for MFLO, otherwise 0. Combinational from the HI/LO register.
- stall_o  out  1  hazard stall request to the pipeline.
- busy_o  out  1  state is not IDLE.
- mul_op_o, div_op_o  out  2  start command, one cycle: 2'b10 signed, 2'b01 unsigned, 2'b00 none.
- mul_a_o, mul_b_o, div_a_o, div_b_o  out  32  operands of the starting slot (dividend is a, divisor is b).
- mul_done_i, div_done_i  in  1  unit done level: high when idle, low from the cycle after a start until the result is valid.
- mul_result_i, div_result_i  in  64  {HI, LO} result, valid while done is high.

## Operation
- Op classes (mdu_op_decode): start = MULT/MULTU/DIV/DIVU; write = MTHI/MTLO; read = MFHI/MFLO.
- Accept condition per slot: stall_i=0, flush_i=0, op is not NONE, and the slot is not blocked (rules below).
- FSM states:
  - IDLE
  - MUL_WAIT, DIV_WAIT: a unit is running and its result will be committed.
  - DRAIN: a flushed op is still running and its result will be discarded.
- Transitions:
  - An accepted start moves IDLE to MUL_WAIT or DIV_WAIT.
  - In a WAIT state, a commit event moves to IDLE. A commit event is a rising edge of the matching done, detected with a registered done_prev.
  - flush_i in a WAIT state moves to DRAIN. In DRAIN, the rising edge of done moves to IDLE with HI/LO unchanged.
- Commit: on a commit event in MUL_WAIT or DIV_WAIT, HI/LO is loaded with the unit result at the end of that cycle.
- Blocking: a slot op of any class is blocked while state is not IDLE. An MFHI issued after a MULT stalls until the commit completes.
- Intra-bundle split:
  - Applies when slot 0 is a start or write and slot 1 is not NONE.
  - Slot 0 executes alone and the internal flag s0_done is set.
  - stall_o is held; slot 0 is treated as NONE while s0_done=1.
  - s0_done clears when slot 1 is accepted, or on flush_i.
- No split is needed in these cases; reads see the pre-write value:
  - Slot 0 is a read and slot 1 is anything.
  - Both slots are reads.
- stall_o = (some non-NONE slot is blocked) | (split pending with s0_done=0), evaluated only when stall_i=0 and flush_i=0; otherwise 0.
- MTHI writes {a, LO}; MTLO writes {HI, a}, at the accept edge.
- At most one HI/LO write per cycle.
- A commit and a write never coincide, because writes are blocked outside IDLE.

## Timing
- Reset: HI/LO = RST_HILO, state IDLE, s0_done=0, done_prev=1; all command outputs 0; stall_o=0 and busy_o=0 with NONE inputs.
- Start: mul_op_o/div_op_o and operands are driven combinationally in the accept cycle N, and busy_o=1 from cycle N+1.
- Commit at the end of cycle C (the done rising edge). state=IDLE in C+1. A stalled MFHI is accepted in C+1 and reads the new value.
- Split sequence: slot 0 is accepted in cycle N. Slot 1 is evaluated from N+1 and is accepted in N+1 at the earliest.
- A flush arriving in the same cycle as a commit event: the commit wins, the result is written, and the next state is IDLE.
- Reset mid-operation: the FSM returns to IDLE and any late done edge is ignored, because done_prev reset is 1.

## Configuration
- MDU_DUAL_ISSUE_EN defined: both slots operate as above.
- Not defined: s1_* inputs are ignored, s1_rdata_o=0, the split logic and s0_done are removed, and stall_o covers slot 0 only.

## Structure
- mdu_pkg holds:
  - mdu_op_t (4-bit enum)
  - the FSM state enum
  - the unit op encodings SIGNED=2'b10, UNSIGNED=2'b01, NONE=2'b00
- Sub-module mdu_op_decode: one instance per slot, pure classifier from mdu_op_t to is_start/is_write/is_read/is_signed/is_mul.

## Test plan
- Reset release; s0 MFHI -> s0_rdata_o=RST_HILO[63:32], stall_o=0.
- s0 MULT a=32'hFFFF_FFFF, b=2 (mul_done_i drops next cycle, rises 4 cycles later with 64'hFFFF_FFFF_FFFF_FFFE), then s0 MFLO -> stall_o=1 until commit, next cycle s0_rdata_o=32'hFFFF_FFFE.
- Bundle s0 MTHI a=32'h1234, s1 MFHI -> one stall cycle, s1_rdata_o=32'h1234 in the following cycle, s0_done cleared.
- Bundle s0 MFLO, s1 DIVU a=7 b=2 -> no stall; s0 reads old LO; div_op_o=01; HI/LO becomes {1,3} at commit.
- DIV issued, flush_i one cycle later -> state DRAIN; the div_done_i rise leaves HI/LO unchanged; busy_o=0 the next cycle.
- With the macro undefined, s1 MTLO a=5 -> HI/LO unchanged, stall_o=0.
